// File: rtl/buffer_w_rd_sched_if.sv
// rtl/buffer_w_rd_sched_if.sv - instruction, buffer read and status signals of the weight read sequencer
interface buffer_w_rd_sched_if #(
  parameter int BUFFER_ADDR_WIDTH = 13,
  parameter int LEN_WIDTH         = 14,
  parameter int REP_WIDTH         = 8
);
  logic                         inst_valid;
  logic                         inst_ready;
  logic [BUFFER_ADDR_WIDTH-1:0] inst_base_addr;
  logic [LEN_WIDTH-1:0]         inst_len;
  logic [REP_WIDTH-1:0]         inst_repeat;
  logic                         mm_read_addr_valid;
  logic [BUFFER_ADDR_WIDTH-1:0] mm_read_addr;
  logic                         mm_read_data_valid;
  logic                         credit_return;
  logic                         busy;
  logic                         done;
  logic                         credit_err;

  modport slave (
    input  inst_valid, inst_base_addr, inst_len, inst_repeat,
    input  mm_read_data_valid, credit_return,
    output inst_ready, mm_read_addr_valid, mm_read_addr, busy, done, credit_err
  );

  modport master (
    output inst_valid, inst_base_addr, inst_len, inst_repeat,
    output mm_read_data_valid, credit_return,
    input  inst_ready, mm_read_addr_valid, mm_read_addr, busy, done, credit_err
  );
endinterface

// File: rtl/buffer_w_rd_sched.sv
// rtl/buffer_w_rd_sched.sv - credit-gated weight buffer read sequencer
// Issues len*passes row reads, one per cycle while credits last, and pulses done once all have returned.
module buffer_w_rd_sched #(
  parameter int BUFFER_ADDR_WIDTH = 13,
  parameter int LEN_WIDTH         = 14,
  parameter int REP_WIDTH         = 8,
  parameter int CREDITS           = 8,
  parameter int READ_LATENCY      = 4
) (
  input logic               clk,
  input logic               rst_n,
  buffer_w_rd_sched_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int OW = $clog2(READ_LATENCY + CREDITS) + 1;
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                       state;
  logic [BUFFER_ADDR_WIDTH-1:0] base_r;
  logic [LEN_WIDTH-1:0]         len_r;
  logic [LEN_WIDTH-1:0]         offset;
  logic [REP_WIDTH-1:0]         passes;
  logic [REP_WIDTH-1:0]         pass;
  logic [CW-1:0]                credits;
  logic [CW-1:0]                credits_next;
  logic [OW-1:0]                outstanding;
  logic [OW-1:0]                out_next;
  logic                         cr_overflow;
  logic                         issue;
  logic                         last_row;
  logic                         last_pass;
  logic [BUFFER_ADDR_WIDTH-1:0] row_addr;

  logic                         inst_ready_r;
  logic                         addr_valid_r;
  logic [BUFFER_ADDR_WIDTH-1:0] addr_r;
  logic                         busy_r;
  logic                         done_r;
  logic                         credit_err_r;

  assign issue     = (state == ISSUE) && (credits != '0);
  assign last_row  = (offset == len_r - LEN_WIDTH'(1));
  assign last_pass = (pass == passes - REP_WIDTH'(1));
  assign row_addr  = base_r + BUFFER_ADDR_WIDTH'(offset);

  // An issue and a return in the same cycle cancel; a return into a full pool is an error.
  always_comb begin
    credits_next = credits;
    cr_overflow  = 1'b0;
    if (issue && !bus.credit_return) begin
      credits_next = credits - CW'(1);
    end else if (!issue && bus.credit_return) begin
      if (credits == CREDITS_MAX) cr_overflow = 1'b1;
      else                        credits_next = credits + CW'(1);
    end

    out_next = outstanding;
    if (issue && !bus.mm_read_data_valid) begin
      out_next = outstanding + OW'(1);
    end else if (!issue && bus.mm_read_data_valid && outstanding != '0) begin
      out_next = outstanding - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_r       <= '0;
      len_r        <= '0;
      offset       <= '0;
      passes       <= '0;
      pass         <= '0;
      credits      <= CREDITS_MAX;
      outstanding  <= '0;
      inst_ready_r <= 1'b1;
      addr_valid_r <= 1'b0;
      addr_r       <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      credit_err_r <= 1'b0;
    end else begin
      credits      <= credits_next;
      outstanding  <= out_next;
      addr_valid_r <= 1'b0;
      addr_r       <= '0;
      done_r       <= 1'b0;
      if (cr_overflow) credit_err_r <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.inst_valid) begin
            base_r       <= bus.inst_base_addr;
            len_r        <= bus.inst_len;
            passes       <= (bus.inst_repeat == '0) ? REP_WIDTH'(1) : bus.inst_repeat;
            offset       <= '0;
            pass         <= '0;
            inst_ready_r <= 1'b0;
            busy_r       <= 1'b1;
            state        <= (bus.inst_len == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_valid_r <= 1'b1;
            addr_r       <= row_addr;
            if (last_row) begin
              offset <= '0;
              pass   <= pass + REP_WIDTH'(1);
              if (last_pass) state <= DRAIN;
            end else begin
              offset <= offset + LEN_WIDTH'(1);
            end
          end
        end
        // Looking at the post-update count lets done follow the final return by one cycle.
        DRAIN: begin
          if (out_next == '0) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          inst_ready_r <= 1'b1;
          busy_r       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inst_ready         = inst_ready_r;
  assign bus.mm_read_addr_valid = addr_valid_r;
  assign bus.mm_read_addr       = addr_r;
  assign bus.busy               = busy_r;
  assign bus.done               = done_r;
  assign bus.credit_err         = credit_err_r;
endmodule

// File: tb/tb_buffer_w_rd_sched.sv
// tb/tb_buffer_w_rd_sched.sv - self-checking bench for buffer_w_rd_sched
module tb_buffer_w_rd_sched;
  localparam int AW = 13, LW = 14, RW = 8, CRED = 8, LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  buffer_w_rd_sched_if #(.BUFFER_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .REP_WIDTH(RW)) bus ();

  buffer_w_rd_sched #(
    .BUFFER_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .REP_WIDTH(RW),
    .CREDITS(CRED), .READ_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Fixed-latency buffer model and downstream credit source
  logic [LAT-1:0] rd_pipe;
  logic cr_tied, cr_manual;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pipe <= '0;
    else        rd_pipe <= {rd_pipe[LAT-2:0], bus.mm_read_addr_valid};
  end
  assign bus.mm_read_data_valid = rd_pipe[LAT-1];
  assign bus.credit_return      = cr_tied ? bus.mm_read_data_valid : cr_manual;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int obs_q[$];
  int obs_cyc_q[$];
  int n_dv = 0, last_dv_cyc = 0, n_done = 0, done_cyc = 0, used = 0, credit_viol = 0;

  always @(negedge clk) begin : mon
    int u;
    if (!rst_n) begin
      used <= 0;
    end else begin
      u = used;
      if (bus.mm_read_addr_valid) begin
        obs_q.push_back(int'(bus.mm_read_addr));
        obs_cyc_q.push_back(cyc);
        u = u + 1;
        if (u > CRED) credit_viol <= credit_viol + 1;
      end
      if (bus.mm_read_data_valid) begin
        n_dv        <= n_dv + 1;
        last_dv_cyc <= cyc;
      end
      if (bus.credit_return && u > 0) u = u - 1;
      used <= u;
      if (bus.done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
    end
  end

  int n_err = 0, n_chk = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send_inst(input int base, input int len, input int rep, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.inst_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("inst_ready_wait", int'(bus.inst_ready), 1);
    bus.inst_base_addr = AW'(base);
    bus.inst_len       = LW'(len);
    bus.inst_repeat    = RW'(rep);
    bus.inst_valid     = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b0;
    acc = cyc;
    check("inst_ready_drop", int'(bus.inst_ready), 0);
  endtask

  task automatic wait_done(input int d0, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk);
      #1;
      if (n_done > d0) ok = 1'b1;
    end
  endtask

  // Reference: rows are base+offset mod 2**AW, offset 0..len-1, repeated max(rep,1) times
  task automatic run_and_check(input int base, input int len, input int rep, input string tag,
                               input bit check_stream, output int first_a, output int last_a,
                               output int rows);
    int i0, dv0, d0, acc, mism, np;
    bit ok;
    int exp_q[$];
    i0 = obs_q.size(); dv0 = n_dv; d0 = n_done;
    np = (rep == 0) ? 1 : rep;
    for (int p = 0; p < np; p++)
      for (int o = 0; o < len; o++)
        exp_q.push_back((base + o) % (1 << AW));
    send_inst(base, len, rep, acc);
    wait_done(d0, 3000, ok);
    check({tag, "_done_seen"}, int'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, n_done - d0, 1);
    rows = obs_q.size() - i0;
    check({tag, "_rows"}, rows, exp_q.size());
    mism = 0;
    for (int k = 0; k < rows && k < exp_q.size(); k++)
      if (obs_q[i0 + k] != exp_q[k]) mism++;
    check({tag, "_addr_mism"}, mism, 0);
    check({tag, "_returns"}, n_dv - dv0, exp_q.size());
    first_a = (rows > 0) ? obs_q[i0] : -1;
    last_a  = (rows > 0) ? obs_q[$] : -1;
    if (exp_q.size() > 0 && rows > 0) begin
      check({tag, "_done_lat"}, done_cyc - last_dv_cyc, 1);
      if (check_stream) check({tag, "_stream"}, obs_cyc_q[$] - obs_cyc_q[i0], rows - 1);
    end
  endtask

  typedef struct {
    int base;
    int len;
    int rep;
    int exp_rows;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int f, l, r, acc, i0, dv0, d0;
    bit ok;

    vecs[0] = '{base: 'h0010, len: 4, rep: 1, exp_rows: 4, exp_first: 'h0010, exp_last: 'h0013};
    vecs[1] = '{base: 'h1FFE, len: 4, rep: 1, exp_rows: 4, exp_first: 'h1FFE, exp_last: 'h0001};
    vecs[2] = '{base: 'h0020, len: 3, rep: 2, exp_rows: 6, exp_first: 'h0020, exp_last: 'h0022};
    vecs[3] = '{base: 'h0040, len: 5, rep: 0, exp_rows: 5, exp_first: 'h0040, exp_last: 'h0044};
    vecs[4] = '{base: 'h1FFF, len: 1, rep: 3, exp_rows: 3, exp_first: 'h1FFF, exp_last: 'h1FFF};

    cr_tied = 1'b1;
    cr_manual = 1'b0;
    bus.inst_valid = 1'b0;
    bus.inst_base_addr = '0;
    bus.inst_len = '0;
    bus.inst_repeat = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_inst_ready", int'(bus.inst_ready), 1);
    check("rst_addr_valid", int'(bus.mm_read_addr_valid), 0);
    check("rst_addr", int'(bus.mm_read_addr), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_credit_err", int'(bus.credit_err), 0);

    for (int i = 0; i < 5; i++) begin
      run_and_check(vecs[i].base, vecs[i].len, vecs[i].rep, $sformatf("vec%0d", i), 1'b1, f, l, r);
      check($sformatf("vec%0d_tbl_rows", i), r, vecs[i].exp_rows);
      check($sformatf("vec%0d_tbl_first", i), f, vecs[i].exp_first);
      check($sformatf("vec%0d_tbl_last", i), l, vecs[i].exp_last);
    end

    for (int i = 0; i < 12; i++) begin
      run_and_check(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), 1'b1, f, l, r);
    end

    // Credit stall: no returns, 12 rows
    cr_tied = 1'b0;
    cr_manual = 1'b0;
    i0 = obs_q.size(); dv0 = n_dv; d0 = n_done;
    send_inst('h200, 12, 1, acc);
    repeat (30) @(posedge clk);
    #1;
    check("stall_issued", obs_q.size() - i0, CRED);
    check("stall_busy", int'(bus.busy), 1);
    for (int k = 0; k < 4; k++) begin
      cr_manual = 1'b1;
      @(posedge clk);
      #1 cr_manual = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check($sformatf("stall_release%0d", k), obs_q.size() - i0, CRED + 1 + k);
    end
    wait_done(d0, 100, ok);
    check("stall_done_seen", int'(ok), 1);
    check("stall_returns", n_dv - dv0, 12);
    check("stall_done_lat", done_cyc - last_dv_cyc, 1);
    check("stall_last_addr", obs_q[$], 'h20B);
    cr_manual = 1'b1;
    repeat (CRED) @(posedge clk);
    #1 cr_manual = 1'b0;
    check("refill_no_err", int'(bus.credit_err), 0);

    // Zero-length instruction, then a return into a full pool
    i0 = obs_q.size(); d0 = n_done;
    send_inst('h300, 0, 3, acc);
    wait_done(d0, 10, ok);
    check("len0_done_seen", int'(ok), 1);
    check("len0_done_within3", int'((done_cyc - acc) >= 1 && (done_cyc - acc) <= 3), 1);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_issue", obs_q.size() - i0, 0);
    cr_manual = 1'b1;
    @(posedge clk);
    #1 cr_manual = 1'b0;
    check("credit_err_set", int'(bus.credit_err), 1);
    repeat (5) @(posedge clk);
    #1;
    check("credit_err_sticky", int'(bus.credit_err), 1);

    // Reset in the middle of a long issue run
    cr_tied = 1'b1;
    send_inst('h100, 100, 1, acc);
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_inst_ready", int'(bus.inst_ready), 1);
    check("mid_rst_addr_valid", int'(bus.mm_read_addr_valid), 0);
    check("mid_rst_addr", int'(bus.mm_read_addr), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_done", int'(bus.done), 0);
    check("mid_rst_credit_err", int'(bus.credit_err), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_inst_ready", int'(bus.inst_ready), 1);
    cr_tied = 1'b0;
    cr_manual = 1'b0;
    run_and_check('h1F0, CRED, 1, "post_rst", 1'b1, f, l, r);

    check("credit_bound", credit_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
